// File: rtl/trace_pkg.sv
// Shared types and constants for the TPIU trace frame receiver.
package trace_pkg;

  typedef enum logic [1:0] {
    W1     = 2'b00,
    W2     = 2'b01,
    W4     = 2'b10,
    W4_ALT = 2'b11
  } width_e;

  localparam logic [31:0] SYNC_WORD           = 32'h7FFF_FFFF;
  localparam int          DEFAULT_FRAME_BYTES = 16;

  typedef struct packed {
    logic       first;
    logic [7:0] data;
  } entry_t;

  // Bits consumed per sample; the reserved code 11 behaves like a 4-bit port.
  function automatic logic [2:0] width_bits(input logic [1:0] w);
    case (width_e'(w))
      W1:      return 3'd1;
      W2:      return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/trace_rx_fifo.sv
// Show-ahead byte FIFO holding {first, data} entries between the aligner and the frame decoder.
module trace_rx_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output entry_t head,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);

  entry_t         mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;

  // The extra top pointer bit separates a full FIFO from an empty one; DEPTH must be a power of two.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/trace_frame_rx.sv
// TPIU trace input stage: hunts for FF FF FF 7F, byte-aligns the stream and queues frame bytes.
// Optional statistics outputs frameCount/syncCount are built when TRACE_RX_STATS_EN is defined.
module trace_frame_rx
  import trace_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int FRAME_BYTES = DEFAULT_FRAME_BYTES
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic [1:0]  width,
  input  logic        sampleEn,
  input  logic [3:0]  traceDin,
  output logic [7:0]  dOut,
  output logic        dFirst,
  output logic        dValid,
  input  logic        dReady,
  output logic        synced,
  output logic        overflow
`ifdef TRACE_RX_STATS_EN
  ,
  output logic [15:0] frameCount,
  output logic [15:0] syncCount
`endif
);

  localparam int             FIW      = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam logic [FIW-1:0] LAST_IDX = FIW'(FRAME_BYTES - 1);

  logic [31:0]     shift_q;
  logic [3:0]      bit_cnt_q;
  logic [FIW-1:0]  frame_idx_q;
  logic [2:0][7:0] pend_q;
  logic [1:0]      pend_cnt_q;
  logic            synced_q;
  logic            overflow_q;
  logic [1:0]      width_q;

  logic [2:0]  w;
  logic [31:0] shifted;
  logic [3:0]  cnt_sum;
  logic        width_chg, match, byte_done, push_req, push_ok, drop, pop;
  logic        full, empty;
  entry_t      push_entry, head;

  always_comb begin
    w = width_bits(width);
    case (w)
      3'd1:    shifted = {traceDin[0],   shift_q[31:1]};
      3'd2:    shifted = {traceDin[1:0], shift_q[31:2]};
      default: shifted = {traceDin[3:0], shift_q[31:4]};
    endcase
    width_chg  = (width != width_q);
    match      = sampleEn && !width_chg && (shifted == SYNC_WORD);
    cnt_sum    = bit_cnt_q + {1'b0, w};
    byte_done  = sampleEn && !width_chg && synced_q && !match && (cnt_sum >= 4'd8);
    push_req   = byte_done && (pend_cnt_q == 2'd3);
    pop        = !empty && dReady;
    push_ok    = push_req && (!full || pop);
    drop       = push_req && full && !pop;
    push_entry = '{first: (frame_idx_q == '0), data: pend_q[0]};
  end

  // A sync match always wins: it realigns and discards the three-byte delay line holding FF FF FF.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      frame_idx_q <= '0;
      pend_q      <= '0;
      pend_cnt_q  <= '0;
      synced_q    <= 1'b0;
      overflow_q  <= 1'b0;
      width_q     <= '0;
    end else begin
      width_q    <= width;
      overflow_q <= drop;
      if (width_chg) begin
        shift_q    <= '0;
        synced_q   <= 1'b0;
        pend_cnt_q <= '0;
        bit_cnt_q  <= '0;
      end else if (sampleEn) begin
        shift_q <= shifted;
        if (match) begin
          synced_q    <= 1'b1;
          bit_cnt_q   <= '0;
          frame_idx_q <= '0;
          pend_cnt_q  <= '0;
        end else if (synced_q) begin
          if (byte_done) begin
            bit_cnt_q <= '0;
            if (drop) begin
              synced_q   <= 1'b0;
              pend_cnt_q <= '0;
            end else begin
              if (pend_cnt_q == 2'd3) begin
                pend_q <= {shifted[31:24], pend_q[2], pend_q[1]};
              end else begin
                pend_q[pend_cnt_q] <= shifted[31:24];
                pend_cnt_q         <= pend_cnt_q + 2'd1;
              end
              if (push_ok) frame_idx_q <= (frame_idx_q == LAST_IDX) ? '0 : frame_idx_q + FIW'(1);
            end
          end else begin
            bit_cnt_q <= cnt_sum;
          end
        end
      end
    end
  end

  trace_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (nRst),
    .push      (push_ok),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  assign dOut     = head.data;
  assign dFirst   = head.first;
  assign dValid   = !empty;
  assign synced   = synced_q;
  assign overflow = overflow_q;

`ifdef TRACE_RX_STATS_EN
  logic [15:0] frame_cnt_q, sync_cnt_q;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      frame_cnt_q <= '0;
      sync_cnt_q  <= '0;
    end else begin
      if (push_ok && (frame_idx_q == LAST_IDX)) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (match) sync_cnt_q <= sync_cnt_q + 16'd1;
    end
  end

  assign frameCount = frame_cnt_q;
  assign syncCount  = sync_cnt_q;
`endif

endmodule

// File: tb/tb_trace_frame_rx.sv
// Scoreboard bench for trace_frame_rx: expected {first, byte} entries are queued as stimulus is sent.
module tb_trace_frame_rx;

  logic       clk;
  logic       nRst;
  logic [1:0] width;
  logic       sampleEn;
  logic [3:0] traceDin;
  logic [7:0] dOut;
  logic       dFirst;
  logic       dValid;
  logic       dReady;
  logic       synced;
  logic       overflow;
`ifdef TRACE_RX_STATS_EN
  logic [15:0] frameCount;
  logic [15:0] syncCount;
`endif

  int         n_checks = 0;
  int         n_fail   = 0;
  int         ovf_count = 0;
  logic [8:0] exp_q[$];

  trace_frame_rx dut (
    .clk      (clk),
    .nRst     (nRst),
    .width    (width),
    .sampleEn (sampleEn),
    .traceDin (traceDin),
    .dOut     (dOut),
    .dFirst   (dFirst),
    .dValid   (dValid),
    .dReady   (dReady),
    .synced   (synced),
    .overflow (overflow)
`ifdef TRACE_RX_STATS_EN
    ,
    .frameCount (frameCount),
    .syncCount  (syncCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: score any pop at the falling edge, then count overflow pulses just after the rising edge.
  task automatic step();
    logic [8:0] e;
    @(negedge clk);
    if (dValid === 1'b1 && dReady === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL unexpected_pop: got first=%b byte=%h, required no output", dFirst, dOut);
      end else begin
        e = exp_q.pop_front();
        if ({dFirst, dOut} !== e) begin
          n_fail++;
          $display("[TB] FAIL scoreboard: got first=%b byte=%h, required first=%b byte=%h",
                   dFirst, dOut, e[8], e[7:0]);
        end
      end
    end
    @(posedge clk);
    #1;
    if (overflow === 1'b1) ovf_count++;
  endtask

  task automatic drive_chunk(input logic [3:0] d);
    sampleEn = 1'b1;
    traceDin = d;
    step();
    sampleEn = 1'b0;
    traceDin = '0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int         w;
    logic [7:0] sh;
    w = (width == 2'b00) ? 1 : (width == 2'b01) ? 2 : 4;
    for (int k = 0; k < 8; k += w) begin
      sh = b >> k;
      drive_chunk(sh[3:0] & 4'((1 << w) - 1));
    end
  endtask

  task automatic send_sync();
    send_byte(8'hFF);
    send_byte(8'hFF);
    send_byte(8'hFF);
    send_byte(8'h7F);
  endtask

  task automatic send_pad();
    for (int i = 0; i < 3; i++) send_byte(8'h55);
  endtask

  task automatic apply_reset();
    nRst     = 1'b0;
    sampleEn = 1'b0;
    traceDin = '0;
    exp_q.delete();
    step();
    step();
    nRst = 1'b1;
    step();
    step();
  endtask

  task automatic drain(input string name);
    dReady = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0 && dValid === 1'b0) break;
      step();
    end
    n_checks++;
    if (exp_q.size() != 0 || dValid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL %s_drain: got %0d entries left, dValid=%b, required 0 entries, dValid=0",
               name, exp_q.size(), dValid);
    end
  endtask

  task automatic test_reset();
    width    = 2'b01;
    dReady   = 1'b0;
    sampleEn = 1'b0;
    traceDin = '0;
    nRst     = 1'b0;
    @(negedge clk);
    n_checks++; if (dOut !== 8'h00)    begin n_fail++; $display("[TB] FAIL reset_dOut: got %h, required 00", dOut); end
    n_checks++; if (dFirst !== 1'b0)   begin n_fail++; $display("[TB] FAIL reset_dFirst: got %b, required 0", dFirst); end
    n_checks++; if (dValid !== 1'b0)   begin n_fail++; $display("[TB] FAIL reset_dValid: got %b, required 0", dValid); end
    n_checks++; if (synced !== 1'b0)   begin n_fail++; $display("[TB] FAIL reset_synced: got %b, required 0", synced); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_overflow: got %b, required 0", overflow); end
    @(posedge clk);
    #1;
    nRst = 1'b1;
    step();
    step();
    n_checks++; if (synced !== 1'b0 || dValid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL post_reset_idle: got synced=%b dValid=%b, required 0 0", synced, dValid);
    end
  endtask

  task automatic test_width2_sync();
    logic [7:0] data [5] = '{8'h42, 8'h71, 8'h19, 8'h69, 8'h12};
    width = 2'b01;
    apply_reset();
    dReady = 1'b1;
    send_byte(8'hFE);
    send_byte(8'h23);
    send_byte(8'hFF);
    send_byte(8'hFF);
    send_byte(8'hFF);
    n_checks++; if (synced !== 1'b0) begin n_fail++; $display("[TB] FAIL w2_presync: got synced=%b, required 0", synced); end
    send_byte(8'h7F);
    n_checks++; if (synced !== 1'b1) begin n_fail++; $display("[TB] FAIL w2_sync_on_7F: got synced=%b, required 1", synced); end
    for (int i = 0; i < 5; i++) exp_q.push_back({(i == 0), data[i]});
    for (int i = 0; i < 5; i++) send_byte(data[i]);
    send_pad();
    drain("w2");
  endtask

  task automatic test_width_1_4();
    logic [1:0] widths [2] = '{2'b00, 2'b10};
    for (int t = 0; t < 2; t++) begin
      width = widths[t];
      apply_reset();
      dReady = 1'b1;
      send_sync();
      for (int i = 0; i < 16; i++) exp_q.push_back({(i == 0), 8'(i)});
      for (int i = 0; i < 16; i++) send_byte(8'(i));
      send_pad();
      drain(t == 0 ? "w1" : "w4");
      n_checks++; if (synced !== 1'b1) begin
        n_fail++; $display("[TB] FAIL w%0d_synced_after_frame: got %b, required 1", t == 0 ? 1 : 4, synced);
      end
    end
  endtask

  task automatic test_overflow();
    width = 2'b10;
    apply_reset();
    dReady    = 1'b0;
    ovf_count = 0;
    for (int i = 0; i < 8; i++) exp_q.push_back({(i == 0), 8'(8'h20 + i)});
    send_sync();
    for (int i = 0; i < 3; i++) send_byte(8'(8'h20 + i));
    n_checks++; if (dValid !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_pending_only: got dValid=%b, required 0", dValid); end
    send_byte(8'h23);
    n_checks++; if (dValid !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_first_push_latency: got dValid=%b, required 1", dValid); end
    for (int i = 4; i < 12; i++) send_byte(8'(8'h20 + i));
    step();
    step();
    n_checks++; if (ovf_count != 1) begin n_fail++; $display("[TB] FAIL ovf_pulse_count: got %0d, required 1", ovf_count); end
    n_checks++; if (synced !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_synced: got %b, required 0", synced); end
    n_checks++; if (dValid !== 1'b1 || dOut !== 8'h20 || dFirst !== 1'b1) begin
      n_fail++; $display("[TB] FAIL ovf_head: got dValid=%b dFirst=%b dOut=%h, required 1 1 20", dValid, dFirst, dOut);
    end
    drain("ovf");
  endtask

  task automatic test_resync();
    width = 2'b01;
    apply_reset();
    dReady = 1'b1;
    send_sync();
    for (int i = 0; i < 5; i++) exp_q.push_back({(i == 0), 8'(8'hAA + i)});
    for (int i = 0; i < 5; i++) send_byte(8'(8'hAA + i));
    send_sync();
    n_checks++; if (synced !== 1'b1) begin n_fail++; $display("[TB] FAIL resync_synced: got %b, required 1", synced); end
    for (int i = 0; i < 4; i++) exp_q.push_back({(i == 0), 8'(8'h10 + i)});
    for (int i = 0; i < 4; i++) send_byte(8'(8'h10 + i));
    send_pad();
    drain("resync");
  endtask

  task automatic test_nrst_midframe();
    width = 2'b00;
    apply_reset();
    dReady = 1'b0;
    send_sync();
    for (int i = 0; i < 6; i++) send_byte(8'(8'h80 + i));
    drive_chunk(4'h1);
    drive_chunk(4'h0);
    nRst = 1'b0;
    #2;
    n_checks++; if (dValid !== 1'b0 || dOut !== 8'h00 || dFirst !== 1'b0) begin
      n_fail++; $display("[TB] FAIL nrst_fifo: got dValid=%b dFirst=%b dOut=%h, required 0 0 00", dValid, dFirst, dOut);
    end
    n_checks++; if (synced !== 1'b0 || overflow !== 1'b0) begin
      n_fail++; $display("[TB] FAIL nrst_status: got synced=%b overflow=%b, required 0 0", synced, overflow);
    end
    step();
    nRst   = 1'b1;
    dReady = 1'b1;
    step();
    for (int i = 0; i < 4; i++) send_byte(8'(8'h12 + 8'h22 * i));
    n_checks++; if (synced !== 1'b0 || dValid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL nrst_no_sync: got synced=%b dValid=%b, required 0 0", synced, dValid);
    end
    send_sync();
    n_checks++; if (synced !== 1'b1) begin n_fail++; $display("[TB] FAIL nrst_resync: got %b, required 1", synced); end
    exp_q.push_back({1'b1, 8'h5A});
    send_byte(8'h5A);
    send_pad();
    drain("nrst");
  endtask

  task automatic test_width_change();
    width = 2'b01;
    apply_reset();
    dReady = 1'b1;
    send_sync();
    exp_q.push_back({1'b1, 8'h30});
    exp_q.push_back({1'b0, 8'h31});
    for (int i = 0; i < 5; i++) send_byte(8'(8'h30 + i));
    drain("wchg_pre");
    n_checks++; if (synced !== 1'b1) begin n_fail++; $display("[TB] FAIL wchg_before: got synced=%b, required 1", synced); end
    width = 2'b10;
    step();
    n_checks++; if (synced !== 1'b0 || overflow !== 1'b0 || dValid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL wchg_cleared: got synced=%b overflow=%b dValid=%b, required 0 0 0", synced, overflow, dValid);
    end
    for (int i = 0; i < 5; i++) send_byte(8'(8'h40 + i));
    n_checks++; if (synced !== 1'b0 || dValid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL wchg_unsynced: got synced=%b dValid=%b, required 0 0", synced, dValid);
    end
    send_sync();
    n_checks++; if (synced !== 1'b1) begin n_fail++; $display("[TB] FAIL wchg_resync: got %b, required 1", synced); end
    exp_q.push_back({1'b1, 8'h50});
    send_byte(8'h50);
    send_pad();
    drain("wchg");
  endtask

`ifdef TRACE_RX_STATS_EN
  task automatic test_stats();
    width = 2'b10;
    apply_reset();
    dReady = 1'b1;
    send_sync();
    for (int i = 0; i < 48; i++) exp_q.push_back({((i % 16) == 0), 8'(8'h60 + i)});
    for (int i = 0; i < 48; i++) send_byte(8'(8'h60 + i));
    send_sync();
    drain("stats");
    n_checks++; if (frameCount !== 16'd3) begin n_fail++; $display("[TB] FAIL stats_frames: got %0d, required 3", frameCount); end
    n_checks++; if (syncCount !== 16'd2) begin n_fail++; $display("[TB] FAIL stats_syncs: got %0d, required 2", syncCount); end
  endtask
`endif

  initial begin
    test_reset();
    test_width2_sync();
    test_width_1_4();
    test_overflow();
    test_resync();
    test_nrst_midframe();
    test_width_change();
`ifdef TRACE_RX_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trace_frame_rx.md
Name: trace_frame_rx

Overview:
- Parametrised successor to the TPIU trace input stage. Takes 1/2/4-bit trace port samples already in the system clock domain, hunts for the TPIU full sync (FF FF FF 7F), then byte-aligns the stream.
- Queues 16-byte frame payload in a byte FIFO with a frame-start marker and a valid/ready handshake.
- Sits between the trace pin sampler and the frame decoder.

Parameters:
- FIFO_DEPTH, 8, byte FIFO entries; power of two, >=4.
- FRAME_BYTES, 16, bytes per TPIU frame; sets the frame-index wrap.

Ports:
- clk  in  1  system clock.
- nRst  in  1  reset, asynchronous, active-low.
- width  in  2  port width: 00=1 bit, 01=2 bits, 10=4 bits, 11 treated as 4 bits.
- sampleEn  in  1  traceDin holds a new chunk this cycle.
- traceDin  in  4  trace chunk, LSB-first; only the low width bits are used.
- dOut  out  8  FIFO head byte.
- dFirst  out  1  dOut is byte 0 of a frame.
- dValid  out  1  FIFO not empty.
- dReady  in  1  consumer takes the head byte when dValid&&dReady.
- synced  out  1  alignment established.
- overflow  out  1  one-cycle pulse: a byte was dropped.

Behaviour:
- Reset: dOut=0, dFirst=0, dValid=0, synced=0, overflow=0; shift register, counters, pending stage and FIFO are cleared. Reset mid-frame discards everything.
- Shift: on sampleEn, a 32-bit shift register shifts right by w (w=1/2/4) and traceDin[w-1:0] enters at the top. Bits arrive oldest-first, LSB-first.
- Sync detect: after each shift, compare the register with SYNC_WORD 32'h7FFF_FFFF at every sampleEn, not only on byte boundaries. On a match:
  - synced<=1;
  - bit counter<=0;
  - frame index<=0;
  - 3-byte pending stage flushed, so sync bytes never reach the FIFO.
- Bit counter: in the same cycle as a match, the match wins over byte completion.
- Byte assembly (synced only): the bit counter adds w per sampleEn. When it reaches 8 it wraps to 0 and the top 8 bits of the shift register form a completed byte.
- Pending stage: a 3-byte delay line holds completed bytes. A new completed byte enters the delay line; when the line is already full, the oldest byte is pushed to the FIFO. This covers the FF FF FF prefix of a mid-stream resync.
- Push tagging: each push carries dFirst=(frame index==0). The frame index then increments and wraps FRAME_BYTES-1 -> 0.
- Resync while synced: realign as above. Bytes already in the FIFO stay; the next pushed byte carries dFirst=1.
- Handshake and latency:
  - FIFO is show-ahead; dOut/dFirst are valid whenever dValid=1.
  - A push into an empty FIFO raises dValid in the following cycle.
  - Pop occurs on dValid&&dReady.
- FIFO full with a push pending:
  - if a pop happens in the same cycle, both proceed and there is no loss;
  - otherwise the byte is dropped, overflow pulses for 1 cycle, and synced<=0. The pending stage and bit counter are cleared, and the sync hunt restarts. FIFO contents are kept.
- Empty FIFO with dReady high: no effect.
- width change: any cycle where width differs from its registered copy clears synced, the pending stage and the shift register. No byte is pushed that cycle.
- Unsynced: bits still shift for sync hunting. No bytes are formed or pushed.

Optional Feature:
- Macro TRACE_RX_STATS_EN.
- Defined: adds outputs frameCount[15:0] and syncCount[15:0]. Both are reset to 0 and wrap at 16'hFFFF.
  - frameCount increments when a push completes frame index FRAME_BYTES-1.
  - syncCount increments on every sync match.
- Undefined: neither port nor its counters exists. Core behaviour is identical.

Decomposition:
- Package trace_pkg:
  - width encoding enum;
  - SYNC_WORD=32'h7FFF_FFFF;
  - default FRAME_BYTES=16;
  - byte+first entry struct (9 bits).
- Sub-module trace_rx_fifo: synchronous show-ahead FIFO, FIFO_DEPTH x 9 bits, with push/pop/full/empty. Pointers have one extra wrap bit to tell full from empty; pointer wrap at FIFO_DEPTH is tested.

Test Plan:
- width=2: junk FE 23, then FF FF FF 7F, then 42 71 19 69 12 with dReady=1. Required: synced rises on the 7F completion; the FIFO sees only 42(dFirst=1) 71 19 ...; no FF/7F byte is ever output.
- width=1 and width=4: sync followed by 16 bytes 00..0F, then 3 padding bytes to flush the pending stage. Required: dOut 00..0F in order, dFirst only on 00; identical across widths.
- dReady=0, FIFO_DEPTH=8: sync then 12 data bytes. Required: 8 bytes queued, dValid=1, one 1-cycle overflow pulse, synced=0. After draining, the first 8 bytes come out intact.
- Mid-frame resync: 5 bytes AA..AE, then FF FF FF 7F, then 10 11 12 13. Required: the next pushed byte after the sync is 10 with dFirst=1; no FF/7F byte is pushed.
- nRst pulsed mid-frame, and separately width changed 2->4 while synced. Required: all outputs return to reset values; synced=0 until a new FF FF FF 7F.
- TRACE_RX_STATS_EN: 3 full frames plus 2 syncs. Required: frameCount=3, syncCount=2; preset to 16'hFFFF then one more frame -> 0.
